// File: rtl/gvp.sv
// Vector-program sequencer: steps x/y/z/u through up to 16 stored vectors,
// strobing section headers and data points, with a single repeat loop.
module gvp (
  input  logic         a_clk,
  input  logic         reset,
  input  logic         pause,
  input  logic         setvec,
  input  logic [511:0] vp_set,
  input  logic [31:0]  reset_options,
  output logic [31:0]  x,
  output logic [31:0]  y,
  output logic [31:0]  z,
  output logic [31:0]  u,
  output logic [31:0]  options,
  output logic [31:0]  section,
  output logic [1:0]   store_data,
  output logic         gvp_finished
);

  typedef enum logic [2:0] {HOLD, LOAD, STEP, NEXT, FIN} state_t;

  state_t state, state_d;

  logic [287:0] mem [16];
  logic [287:0] rd;
  logic [31:0]  rd_n, rd_nii, rd_opt, rd_nrep, rd_nxt;

  logic [3:0]  pc, pc_d;
  logic        loop_idle, loop_idle_d;
  logic [31:0] loop_cnt, loop_cnt_d;
  logic [31:0] pt_cnt, pt_cnt_d;
  logic [31:0] wait_cnt, wait_cnt_d;
  logic [31:0] nii_r, nii_d;
  logic [31:0] nrep_r, nrep_d;
  logic [31:0] opt_r, opt_d;
  logic [3:0]  nxt_r, nxt_d;
  logic        loop_en_r, loop_en_d;
  logic [31:0] dx_r, dy_r, dz_r, du_r;
  logic [31:0] dx_d, dy_d, dz_d, du_d;
  logic [31:0] x_d, y_d, z_d, u_d, section_d;
  logic [1:0]  store_d;
  logic        fin_d;
  logic        unused_bits;

  assign unused_bits = ^{vp_set[511:320], vp_set[31:4]};

  // Vector memory has no reset so a program loaded while held survives release.
  always_ff @(posedge a_clk) begin
    if (setvec) mem[vp_set[3:0]] <= vp_set[319:32];
  end

  assign rd      = mem[pc];
  assign rd_n    = rd[31:0];
  assign rd_nii  = rd[63:32];
  assign rd_opt  = rd[95:64];
  assign rd_nrep = rd[127:96];
  assign rd_nxt  = rd[159:128];

  assign options = (state == HOLD || state == FIN) ? reset_options : opt_r;

  always_ff @(posedge a_clk or negedge reset) begin
    if (!reset) begin
      state        <= HOLD;
      pc           <= '0;
      loop_idle    <= 1'b1;
      loop_cnt     <= '0;
      pt_cnt       <= '0;
      wait_cnt     <= '0;
      nii_r        <= '0;
      nrep_r       <= '0;
      opt_r        <= '0;
      nxt_r        <= '0;
      loop_en_r    <= 1'b0;
      dx_r         <= '0;
      dy_r         <= '0;
      dz_r         <= '0;
      du_r         <= '0;
      x            <= '0;
      y            <= '0;
      z            <= '0;
      u            <= '0;
      section      <= '0;
      store_data   <= '0;
      gvp_finished <= 1'b0;
    end else begin
      state        <= state_d;
      pc           <= pc_d;
      loop_idle    <= loop_idle_d;
      loop_cnt     <= loop_cnt_d;
      pt_cnt       <= pt_cnt_d;
      wait_cnt     <= wait_cnt_d;
      nii_r        <= nii_d;
      nrep_r       <= nrep_d;
      opt_r        <= opt_d;
      nxt_r        <= nxt_d;
      loop_en_r    <= loop_en_d;
      dx_r         <= dx_d;
      dy_r         <= dy_d;
      dz_r         <= dz_d;
      du_r         <= du_d;
      x            <= x_d;
      y            <= y_d;
      z            <= z_d;
      u            <= u_d;
      section      <= section_d;
      store_data   <= store_d;
      gvp_finished <= fin_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    loop_idle_d = loop_idle;
    loop_cnt_d  = loop_cnt;
    pt_cnt_d    = pt_cnt;
    wait_cnt_d  = wait_cnt;
    nii_d       = nii_r;
    nrep_d      = nrep_r;
    opt_d       = opt_r;
    nxt_d       = nxt_r;
    loop_en_d   = loop_en_r;
    dx_d        = dx_r;
    dy_d        = dy_r;
    dz_d        = dz_r;
    du_d        = du_r;
    x_d         = x;
    y_d         = y;
    z_d         = z;
    u_d         = u;
    section_d   = section;
    store_d     = '0;
    fin_d       = gvp_finished;

    if (!pause) begin
      unique case (state)
        HOLD: state_d = LOAD;
        LOAD: begin
          if (rd_n == '0 && rd_opt == '0) begin
            state_d = FIN;
            fin_d   = 1'b1;
          end else begin
            // Only the low nibble of Next matters for pc, so the loop
            // enable is decided here from the full 32-bit fields.
            nii_d      = rd_nii;
            nrep_d     = rd_nrep;
            opt_d      = rd_opt;
            nxt_d      = rd_nxt[3:0];
            loop_en_d  = (rd_nrep != '0) && (rd_nxt != '0);
            dx_d       = rd[191:160];
            dy_d       = rd[223:192];
            dz_d       = rd[255:224];
            du_d       = rd[287:256];
            pt_cnt_d   = rd_n;
            wait_cnt_d = rd_nii;
            store_d    = 2'd2;
            section_d  = {28'd0, pc};
            state_d    = (rd_n == '0) ? NEXT : STEP;
          end
        end
        STEP: begin
          if (wait_cnt != '0) begin
            wait_cnt_d = wait_cnt - 32'd1;
          end else begin
            x_d        = x + dx_r;
            y_d        = y + dy_r;
            z_d        = z + dz_r;
            u_d        = u + du_r;
            store_d    = 2'd1;
            pt_cnt_d   = pt_cnt - 32'd1;
            wait_cnt_d = nii_r;
            if (pt_cnt == 32'd1) state_d = NEXT;
          end
        end
        NEXT: begin
          if (loop_en_r) begin
            if (loop_idle) begin
              loop_cnt_d  = nrep_r - 32'd1;
              loop_idle_d = 1'b0;
              pc_d        = pc + nxt_r;
            end else if (loop_cnt != '0) begin
              loop_cnt_d = loop_cnt - 32'd1;
              pc_d       = pc + nxt_r;
            end else begin
              loop_idle_d = 1'b1;
              pc_d        = pc + 4'd1;
            end
          end else begin
            pc_d = pc + 4'd1;
          end
          state_d = LOAD;
        end
        FIN:     state_d = FIN;
        default: state_d = HOLD;
      endcase
    end
  end

endmodule

// File: tb/tb_gvp.sv
// Bench for gvp: table-driven programs checked by a scoreboard of expected
// strobes, plus pause and mid-run abort sequences.
module tb_gvp;

  logic         a_clk = 1'b0;
  logic         reset, pause, setvec;
  logic [511:0] vp_set;
  logic [31:0]  reset_options;
  logic [31:0]  x, y, z, u, options, section;
  logic [1:0]   store_data;
  logic         gvp_finished;

  gvp dut (
    .a_clk(a_clk), .reset(reset), .pause(pause), .setvec(setvec),
    .vp_set(vp_set), .reset_options(reset_options),
    .x(x), .y(y), .z(z), .u(u), .options(options), .section(section),
    .store_data(store_data), .gvp_finished(gvp_finished)
  );

  initial forever #5 a_clk = ~a_clk;

  typedef struct { int prog; int adr; int n, nii, opt, nrep, nxt, dx, dy, dz, du; } vrec_t;
  typedef struct { int x, y, z, u, hdr, pts; } exp_t;
  typedef struct { int kind; int sec; int opt; int x, y, z, u; int e; } ev_t;

  vrec_t vtab[10];
  exp_t  etab[3];
  vrec_t mem_m[16];
  ev_t   ev_q[$];
  ev_t   mev;
  int    strobe_e[$];
  int    total = 0, bad = 0, edge_cnt = 0, hdr_cnt = 0, pts_cnt = 0, fin_model = 0;
  bit    timing_chk = 1'b1;
  logic [31:0] snap_x, snap_y, snap_u, snap_sec;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h required %0h (edge %0d)", nm, act, exp, edge_cnt);
    end
  endtask

  // Counts rising edges since reset release.
  initial forever begin
    @(posedge a_clk or negedge reset);
    if (reset !== 1'b1) edge_cnt = 0;
    else edge_cnt++;
  end

  initial forever begin
    @(negedge a_clk);
    if (reset === 1'b1 && store_data != 2'd0) begin
      strobe_e.push_back(edge_cnt);
      if (store_data == 2'd2) hdr_cnt++;
      else pts_cnt++;
      if (ev_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL extra_strobe: got store_data=%0d at edge %0d required none", store_data, edge_cnt);
      end else begin
        mev = ev_q.pop_front();
        chk("strobe_kind", 32'(store_data), mev.kind);
        chk("strobe_x", x, mev.x);
        chk("strobe_y", y, mev.y);
        chk("strobe_z", z, mev.z);
        chk("strobe_u", u, mev.u);
        if (mev.kind == 2) begin
          chk("hdr_section", section, mev.sec);
          chk("hdr_options", options, mev.opt);
        end
        if (timing_chk) chk("strobe_edge", edge_cnt, mev.e);
      end
    end
  end

  task automatic write_vec(input vrec_t v);
    @(negedge a_clk);
    vp_set = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              v.du, v.dz, v.dy, v.dx, v.nxt, v.nrep, v.opt, v.nii, v.n,
              28'h5A5A5A5, 4'(v.adr)};
    setvec = 1'b1;
    mem_m[v.adr] = v;
    @(negedge a_clk);
    setvec = 1'b0;
  endtask

  task automatic load_prog(input int p);
    for (int i = 0; i < 10; i++)
      if (vtab[i].prog == p) write_vec(vtab[i]);
  endtask

  // Walks the stored program and queues every strobe with its release-relative edge.
  task automatic gen_model();
    int pc = 0, lc = 0, e = 1;
    bit idle = 1'b1;
    int mx = 0, my = 0, mz = 0, mu = 0;
    vrec_t v;
    ev_q.delete();
    for (int guard = 0; guard < 4096; guard++) begin
      v = mem_m[pc];
      e++;
      if (v.n == 0 && v.opt == 0) break;
      ev_q.push_back('{2, pc, v.opt, mx, my, mz, mu, e});
      for (int p = 0; p < v.n; p++) begin
        e += v.nii + 1;
        mx += v.dx; my += v.dy; mz += v.dz; mu += v.du;
        ev_q.push_back('{1, pc, v.opt, mx, my, mz, mu, e});
      end
      if (v.nrep != 0 && v.nxt != 0) begin
        if (idle) begin
          lc = v.nrep - 1; idle = 1'b0; pc = (pc + v.nxt) & 15;
        end else if (lc != 0) begin
          lc--; pc = (pc + v.nxt) & 15;
        end else begin
          idle = 1'b1; pc = (pc + 1) & 15;
        end
      end else begin
        pc = (pc + 1) & 15;
      end
      e++;
    end
    fin_model = e;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_x"}, x, 0);
    chk({tag, "_y"}, y, 0);
    chk({tag, "_z"}, z, 0);
    chk({tag, "_u"}, u, 0);
    chk({tag, "_store"}, 32'(store_data), 0);
    chk({tag, "_fin"}, 32'(gvp_finished), 0);
    chk({tag, "_section"}, section, 0);
    chk({tag, "_options"}, options, reset_options);
  endtask

  task automatic start_run();
    gen_model();
    hdr_cnt = 0;
    pts_cnt = 0;
    strobe_e.delete();
    @(negedge a_clk);
    reset = 1'b1;
  endtask

  task automatic finish_run(input int p, input int extra);
    while (gvp_finished !== 1'b1 && edge_cnt < fin_model + extra + 100) @(negedge a_clk);
    chk("fin_edge", edge_cnt, fin_model + extra);
    chk("fin_x", x, etab[p].x);
    chk("fin_y", y, etab[p].y);
    chk("fin_z", z, etab[p].z);
    chk("fin_u", u, etab[p].u);
    chk("hdr_count", hdr_cnt, etab[p].hdr);
    chk("pts_count", pts_cnt, etab[p].pts);
    chk("events_left", ev_q.size(), 0);
    chk("fin_options", options, reset_options);
    repeat (3) @(negedge a_clk);
    chk("fin_hold_flag", 32'(gvp_finished), 1);
    chk("fin_hold_store", 32'(store_data), 0);
    chk("fin_hold_y", y, etab[p].y);
  endtask

  initial begin
    vtab[0] = '{0, 0, 5, 2, 1, 0, 0, -2, -2, 0, 1};
    vtab[1] = '{0, 1, 5, 2, 1, 0, 0, 2, 2, 0, -1};
    vtab[2] = '{0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vtab[3] = '{1, 0, 10, 2, 0, 0, 0, 2, 0, 0, 0};
    vtab[4] = '{1, 1, 10, 2, 0, 0, 0, -2, 0, 0, 0};
    vtab[5] = '{1, 2, 1, 2, 0, 10, -2, 0, 2, 0, 0};
    vtab[6] = '{1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vtab[7] = '{2, 0, 0, 3, 5, 0, 0, 9, 9, 9, 9};
    vtab[8] = '{2, 1, 2, 0, 0, 2, 16, 0, 0, 7, 0};
    vtab[9] = '{2, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    etab[0] = '{0, 0, 0, 0, 2, 10};
    etab[1] = '{0, 22, 0, 0, 33, 231};
    etab[2] = '{0, 0, 42, 0, 4, 6};
    for (int i = 0; i < 16; i++) mem_m[i] = '{0, i, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    reset = 1'b0; pause = 1'b0; setvec = 1'b0; vp_set = '0;
    reset_options = 32'h5A5A_0001;
    repeat (2) @(negedge a_clk);
    chk_reset_vals("rst");
    reset_options = 32'h1234_5678;
    #1 chk("rst_options_follow", options, 32'h1234_5678);

    for (int p = 0; p < 3; p++) begin
      load_prog(p);
      timing_chk = 1'b1;
      start_run();
      if (p == 0) begin
        while (edge_cnt < 17) @(negedge a_clk);
        chk("v0_end_x", x, -10);
        chk("v0_end_y", y, -10);
        chk("v0_end_u", u, 5);
      end
      finish_run(p, 0);
      if (p == 0) begin
        chk("strobes_ge3", 32'(strobe_e.size() >= 3), 1);
        if (strobe_e.size() >= 3) begin
          chk("hdr_to_pt_gap", strobe_e[1] - strobe_e[0], 3);
          chk("pt_to_pt_gap", strobe_e[2] - strobe_e[1], 3);
        end
      end
      @(negedge a_clk);
      reset = 1'b0;
      #1 chk_reset_vals("rst_after_fin");
    end

    // Freeze for 7 edges in the middle of the first section.
    load_prog(0);
    timing_chk = 1'b0;
    start_run();
    while (edge_cnt < 8) @(negedge a_clk);
    pause = 1'b1;
    snap_x = x; snap_y = y; snap_u = u; snap_sec = section;
    repeat (7) begin
      @(negedge a_clk);
      chk("pause_store", 32'(store_data), 0);
      chk("pause_x", x, snap_x);
      chk("pause_y", y, snap_y);
      chk("pause_u", u, snap_u);
      chk("pause_section", section, snap_sec);
    end
    pause = 1'b0;
    finish_run(0, 7);
    @(negedge a_clk);
    reset = 1'b0;

    // Abort a scan mid-flight, then release again without reprogramming.
    load_prog(1);
    timing_chk = 1'b1;
    start_run();
    while (edge_cnt < 100) @(negedge a_clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals("abort");
    ev_q.delete();
    @(negedge a_clk);
    start_run();
    finish_run(1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gvp.md
GVP -- requirements
Module: gvp

Interface
REQ-001 SHALL have no parameters; vector memory depth fixed at 16 entries (address = Vadr[3:0]).
REQ-002 a_clk  in  1  single clock; all logic on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset/hold; low = held in reset, high = run.
REQ-004 pause  in  1  high freezes the sequencer (counters, positions, state).
REQ-005 setvec  in  1  high writes vp_set into vector memory at Vadr, sampled each a_clk edge.
REQ-006 vp_set  in  512  vector record: [31:0] Vadr, [63:32] N, [95:64] NII, [127:96] Options, [159:128] Nrep, [191:160] Next (signed), [223:192] dx, [255:224] dy, [287:256] dz, [319:288] du (all d signed); [511:320] ignored.
REQ-007 reset_options  in  32  value driven on options while in reset or finished.
REQ-008 x, y, z, u  out  32 each  signed position accumulators.
REQ-009 options  out  32  Options field of the active vector.
REQ-010 section  out  32  address of the active vector.
REQ-011 store_data  out  2  one-cycle strobe: 2 = section header, 1 = data point, 0 = none.
REQ-012 gvp_finished  out  1  high once END vector reached.

Function
REQ-013 Vector memory SHALL NOT be cleared by reset; setvec writes SHALL be accepted in any state, including reset.
REQ-014 States: HOLD, LOAD, STEP, NEXT, FIN.
REQ-015 Reset low: state HOLD, pc=0, loop counter idle, x=y=z=u=0, store_data=0, gvp_finished=0, section=0, options=reset_options.
REQ-016 First edge after reset goes high: HOLD->LOAD.
REQ-017 LOAD (1 cycle): read mem[pc]; if N==0 and Options==0 -> FIN; else latch record, point counter=N, wait counter=NII, store_data=2, section=pc, options=Options, -> STEP.
REQ-018 STEP: each point takes NII+1 cycles: NII wait cycles, then one cycle adding dx,dy,dz,du to x,y,z,u (two's complement, wrap mod 2^32) with store_data=1; point counter decrements; at 0 -> NEXT.
REQ-019 NEXT (1 cycle): if Nrep!=0 and Next!=0: loop counter idle -> load Nrep-1, pc=pc+Next; loop counter >0 -> decrement, pc=pc+Next; loop counter exhausted -> counter idle, pc=pc+1. If Nrep==0 or Next==0: pc=pc+1. Then -> LOAD. Net effect: looped block executes Nrep+1 times; single (non-nested) loop counter.
REQ-020 pc arithmetic SHALL be modulo 16.
REQ-021 FIN: gvp_finished=1, store_data=0, positions held, options=reset_options; remain until reset goes low.
REQ-022 pause high: no state, counter or position change; store_data=0; resumes exactly where frozen.
REQ-023 Reset low mid-operation SHALL abort immediately (asynchronous) to HOLD values of REQ-015.
REQ-024 N==0 with Options!=0: section header issued, no points, -> NEXT.

Reset
REQ-025 All outputs and state registers asynchronously reset per REQ-015; only vector memory is unreset.

Verification
REQ-026 Program, during reset: v0 {N=5,NII=2,Opt=1,dx=-2,dy=-2,du=1}, v1 {N=5,NII=2,Opt=1,dx=2,dy=2,du=-1}, v2 END; release -> after v0 x=y=-10,u=5; at finish x=y=z=u=0, gvp_finished=1, two store_data=2 strobes, ten store_data=1 strobes.
REQ-027 Scan: v0 {N=10,NII=2,dx=2}, v1 {N=10,NII=2,dx=-2}, v2 {N=1,NII=2,dy=2,Nrep=10,Next=-2}, v3 END -> finish with x=0, y=22, 33 headers, 231 points.
REQ-028 Point timing: NII=2 -> store_data=1 strobes exactly 3 cycles apart; header 1 cycle before first wait cycle.
REQ-029 Pause asserted for 7 cycles mid-section -> positions, section, counters unchanged; completion delayed by exactly 7 cycles.
REQ-030 Reset low mid-scan -> outputs immediately at reset values; re-release reruns program from v0 unchanged.
